// File: rtl/multicycle_controller.sv
// Main controller for a multicycle RISC-V core: a Moore FSM with configurable memory wait states.
// Define MULTICYCLE_JALR_EN to add jalr support (JALR and LINK states).
module multicycle_controller #(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTICYCLE_JALR_EN
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  localparam logic [WAIT_W-1:0] CNT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1'b1);
  localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
`ifdef MULTICYCLE_JALR_EN
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
`endif
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [WAIT_W-1:0] count_r;
  logic [WAIT_W-1:0] next_count_s;
  logic              illegal_r;
  logic              wait_state_s;
  logic              last_s;
  logic              pc_update_s;
  logic              branch_s;

  function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
    logic [1:0] sel;
    case (opcode)
      OP_STORE:  sel = 2'b01;
      OP_BRANCH: sel = 2'b10;
      OP_JAL:    sel = 2'b11;
      default:   sel = 2'b00;
    endcase
    return sel;
  endfunction

  // State, wait counter and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      count_r   <= CNT_ZERO;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      count_r   <= next_count_s;
      illegal_r <= illegal_r | (next_state_s == S_ILLEGAL);
    end
  end

  // Memory-facing states stretch to MEM_WAIT+1 cycles; counter restarts at 0 in every new state
  always_comb begin
    wait_state_s = 1'b0;
    case (state_r)
      S_FETCH, S_MEMREAD, S_MEMWRITE: wait_state_s = 1'b1;
      default:                        wait_state_s = 1'b0;
    endcase
    last_s = (count_r == CNT_LAST);
    if (wait_state_s && !last_s) begin
      next_count_s = count_r + CNT_ONE;
    end else begin
      next_count_s = CNT_ZERO;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (last_s) next_state_s = S_DECODE;
        else        next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_JAL:            next_state_s = S_JAL;
          OP_BRANCH:         next_state_s = S_BEQ;
`ifdef MULTICYCLE_JALR_EN
          OP_JALR:           next_state_s = S_JALR;
`endif
          default:           next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) next_state_s = S_MEMREAD;
        else               next_state_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (last_s) next_state_s = S_MEMWB;
        else        next_state_s = S_MEMREAD;
      end
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: begin
        if (last_s) next_state_s = S_FETCH;
        else        next_state_s = S_MEMWRITE;
      end
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_JAL:      next_state_s = S_ALUWB;
`ifdef MULTICYCLE_JALR_EN
      S_JALR:     next_state_s = S_LINK;
      S_LINK:     next_state_s = S_ALUWB;
`endif
      S_ALUWB:    next_state_s = S_FETCH;
      S_BEQ:      next_state_s = S_FETCH;
      S_ILLEGAL:  next_state_s = S_ILLEGAL;
      default:    next_state_s = S_ILLEGAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (last_s) begin
          ir_write    = 1'b1;
          pc_update_s = 1'b1;
        end else begin
          ir_write    = 1'b0;
          pc_update_s = 1'b0;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch_s  = 1'b1;
      end
`ifdef MULTICYCLE_JALR_EN
      S_JALR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        result_src  = 2'b10;
        pc_update_s = 1'b1;
      end
      S_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
`endif
      S_ILLEGAL: adr_src = 1'b0;
      default:   adr_src = 1'b0;
    endcase
  end

  assign pc_write = pc_update_s | (branch_s & zero);
  assign imm_src  = imm_decode(op);
  assign illegal  = illegal_r;
  assign state    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: one instance with MEM_WAIT=0 and one with MEM_WAIT=2,
// checked by vector tables, hand sequences and a random run against an instruction-level model.
module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] JALO  = 7'b1101111;
  localparam logic [6:0] BEQO  = 7'b1100011;
  localparam logic [6:0] JALRO = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst_v  [2];
  logic [6:0]  op_v   [2];
  logic        zero_v [2];
  logic [19:0] obs    [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
  //        alu_src_b, alu_op, imm_src, illegal, state}
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
      logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
      logic [3:0] state;
      multicycle_controller #(.MEM_WAIT(g * 2), .WAIT_W(4)) dut (
        .clk(clk), .reset(rst_v[g]), .op(op_v[g]), .zero(zero_v[g]),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .illegal(illegal), .state(state)
      );
      assign obs[g] = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                       alu_src_a, alu_src_b, alu_op, imm_src, illegal, state};
    end
  endgenerate

  typedef struct packed {
    logic [3:0] st;
    logic       last;
  } rec_t;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    int          len;
    logic [23:0] sts;
    int          pcw_n;
    int          rw_cyc;
  } vec_t;

  rec_t  exp_q[$];
  vec_t  vecs[$];
  vec_t  cur;
  int    pcw;
  logic [31:0] st16, ir16, mw16;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Expected output word for one cycle, straight from the per-state output table.
  function automatic logic [19:0] exp_obs(input logic [3:0] st, input logic last,
                                          input logic [6:0] op, input logic zero);
    logic pcw_e, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, ao, imm;
    pcw_e = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
    rs = 2'd0; a = 2'd0; b = 2'd0; ao = 2'd0;
    case (st)
      4'd0:  begin b = 2'd2; rs = 2'd2; irw = last; pcw_e = last; end
      4'd1:  begin a = 2'd1; b = 2'd1; end
      4'd2:  begin a = 2'd2; b = 2'd1; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'd1; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  begin a = 2'd2; ao = 2'd2; end
      4'd7:  rw = 1'b1;
      4'd8:  begin a = 2'd2; b = 2'd1; ao = 2'd2; end
      4'd9:  begin a = 2'd1; b = 2'd2; pcw_e = 1'b1; end
      4'd10: begin a = 2'd2; ao = 2'd1; pcw_e = zero; end
      4'd11: begin a = 2'd2; b = 2'd1; rs = 2'd2; pcw_e = 1'b1; end
      4'd12: begin a = 2'd1; b = 2'd2; end
      4'd15: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    if (op == SW)        imm = 2'd1;
    else if (op == BEQO) imm = 2'd2;
    else if (op == JALO) imm = 2'd3;
    else                 imm = 2'd0;
    return {pcw_e, adr, mw, irw, rw, rs, a, b, ao, imm, ill, st};
  endfunction

  task automatic push(input logic [3:0] st, input logic last);
    rec_t r;
    r.st = st;
    r.last = last;
    exp_q.push_back(r);
  endtask

  // Instruction-level model: the state sequence one instruction walks through.
  task automatic build(input logic [6:0] op, input int mw);
    exp_q.delete();
    for (int i = 0; i <= mw; i++) push(4'd0, (i == mw));
    push(4'd1, 1'b0);
    if (op == LW) begin
      push(4'd2, 1'b0);
      for (int i = 0; i <= mw; i++) push(4'd3, 1'b0);
      push(4'd4, 1'b0);
    end else if (op == SW) begin
      push(4'd2, 1'b0);
      for (int i = 0; i <= mw; i++) push(4'd5, 1'b0);
    end else if (op == RT) begin
      push(4'd6, 1'b0); push(4'd7, 1'b0);
    end else if (op == IT) begin
      push(4'd8, 1'b0); push(4'd7, 1'b0);
    end else if (op == JALO) begin
      push(4'd9, 1'b0); push(4'd7, 1'b0);
    end else if (op == BEQO) begin
      push(4'd10, 1'b0);
`ifdef MULTICYCLE_JALR_EN
    end else if (op == JALRO) begin
      push(4'd11, 1'b0); push(4'd12, 1'b0); push(4'd7, 1'b0);
`endif
    end else begin
      for (int i = 0; i < 4; i++) push(4'd15, 1'b0);
    end
  endtask

  task automatic use_dut(input int k);
    rst_v[k]     = 1'b0;
    rst_v[1 - k] = 1'b1;
  endtask

  task automatic run_model(input int k, input logic [6:0] op, input logic zero);
    use_dut(k);
    op_v[k] = op;
    zero_v[k] = zero;
    build(op, k * 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      check("model_cycle", obs[k], exp_obs(exp_q[i].st, exp_q[i].last, op, zero));
      @(negedge clk);
    end
    if (exp_q[exp_q.size() - 1].st == 4'd15) begin
      rst_v[k] = 1'b1;
      #1;
      check("model_ill_reset", obs[k][4:0], 5'd0);
      @(negedge clk);
      rst_v[k] = 1'b0;
    end
  endtask

  task automatic illegal_seq(input logic [6:0] op);
    use_dut(0);
    op_v[0] = op;
    #1; check("ill_fetch", obs[0][3:0], 4'd0);
    @(negedge clk);
    #1; check("ill_decode", obs[0][3:0], 4'd1);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      #1; check("ill_hold", obs[0][4:0], 5'h1F);
      @(negedge clk);
    end
    rst_v[0] = 1'b1;
    #1; check("ill_reset", obs[0][4:0], 5'd0);
    @(negedge clk);
    rst_v[0] = 1'b0;
  endtask

  task automatic add_vec(input logic [6:0] op, input logic zero, input int len,
                         input logic [23:0] sts, input int pcw_n, input int rw_cyc);
    vec_t v;
    v.op = op; v.zero = zero; v.len = len; v.sts = sts; v.pcw_n = pcw_n; v.rw_cyc = rw_cyc;
    vecs.push_back(v);
  endtask

  initial begin
    // {op, zero, cycles, states (nibble per cycle, first in LSBs), pc_write count, reg_write cycle}
    add_vec(LW,   1'b0, 5, 24'h043210, 1, 4);
    add_vec(SW,   1'b0, 4, 24'h005210, 1, -1);
    add_vec(RT,   1'b0, 4, 24'h007610, 1, 3);
    add_vec(IT,   1'b1, 4, 24'h007810, 1, 3);
    add_vec(JALO, 1'b0, 4, 24'h007910, 2, 3);
    add_vec(BEQO, 1'b1, 3, 24'h000A10, 2, -1);
    add_vec(BEQO, 1'b0, 3, 24'h000A10, 1, -1);
`ifdef MULTICYCLE_JALR_EN
    add_vec(JALRO, 1'b0, 5, 24'h07CB10, 2, 4);
`endif

    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    op_v[0] = 7'd0; op_v[1] = 7'd0;
    zero_v[0] = 1'b0; zero_v[1] = 1'b0;
    @(negedge clk);
    #1;
    check("reset_dut0", obs[0], exp_obs(4'd0, 1'b1, 7'd0, 1'b0));
    check("reset_dut2", obs[1], exp_obs(4'd0, 1'b0, 7'd0, 1'b0));

    use_dut(0);
    for (int v = 0; v < vecs.size(); v++) begin
      cur = vecs[v];
      op_v[0] = cur.op;
      zero_v[0] = cur.zero;
      pcw = 0;
      for (int c = 0; c < cur.len; c++) begin
        #1;
        check("tbl_state", obs[0][3:0], cur.sts[4 * c +: 4]);
        check("tbl_reg_write", obs[0][15], (c == cur.rw_cyc));
        pcw += int'(obs[0][19]);
        @(negedge clk);
      end
      #1;
      check("tbl_return_fetch", obs[0][3:0], 4'd0);
      check("tbl_pc_write_count", pcw, cur.pcw_n);
    end

    illegal_seq(7'b0000000);
`ifndef MULTICYCLE_JALR_EN
    illegal_seq(JALRO);
`endif

    // sw with MEM_WAIT=2: FETCH x3 (ir_write on 3rd), DECODE, MEMADR, MEMWRITE x3
    use_dut(1);
    op_v[1] = SW;
    zero_v[1] = 1'b0;
    st16 = 32'h55521000;
    ir16 = 32'h00000004;
    mw16 = 32'h000000E0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("mw2_state", obs[1][3:0], st16[4 * c +: 4]);
      check("mw2_ir_write", obs[1][16], ir16[c]);
      check("mw2_mem_write", obs[1][17], mw16[c]);
      @(negedge clk);
    end
    #1;
    check("mw2_return_fetch", obs[1][3:0], 4'd0);
    repeat (6) @(negedge clk);
    #1;
    check("midwrite_pre", obs[1][17], 1'b1);
    check("midwrite_pre_state", obs[1][3:0], 4'd5);
    rst_v[1] = 1'b1;
    #1;
    check("midwrite_mem_write_drop", obs[1][17], 1'b0);
    check("midwrite_state", obs[1][3:0], 4'd0);
    @(negedge clk);
    rst_v[1] = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [6:0] rop;
      int pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = JALO;
        5: rop = BEQO;
        6: rop = JALRO;
        default: rop = 7'($urandom);
      endcase
      run_model(i % 2, rop, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
